// File: rtl/controller.sv
// controller: main decode and control unit for the 5-stage 16-bit MIPS-style pipeline.
// ID-stage selects and flags are decoded combinationally; EX, MEM and WB control
// travel down the ID/EX, EX/MEM and MEM/WB pipeline registers.
module controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] opcode,
  input  logic [2:0] functionCode,
  input  logic       Z,
  input  logic       stall,
  output logic       RegSrc1,
  output logic [1:0] RegSrc2,
  output logic       RegDest,
  output logic       sign_extend_imm,
  output logic [1:0] PCSrc,
  output logic       killF,
  output logic       PCsrcJType,
  output logic       RRSrc,
  output logic       NOOP,
  output logic       CntInst,
  output logic       ALUInst,
  output logic       BRANCH_OR_FOR,
  output logic       DMemWr,
  output logic [2:0] EXALUOp,
  output logic       EXALUSrc,
  output logic       EXMemDataIn,
  output logic       EXRegWr,
  output logic       EXMemRd,
  output logic       EXMemWr,
  output logic       MEMMemRd,
  output logic       MEMMemWr,
  output logic       MEMRegWr,
  output logic       MEMWBdata,
  output logic       WBRegWr
);

  localparam int unsigned OP_W   = 4;
  localparam int unsigned FUNC_W = 3;
  localparam int unsigned ALU_W  = 3;
  localparam int unsigned PC_W   = 2;

  localparam logic [OP_W-1:0] OP_RTYPE = 4'b0000;
  localparam logic [OP_W-1:0] OP_JTYPE = 4'b0001;
  localparam logic [OP_W-1:0] OP_ANDI  = 4'b0010;
  localparam logic [OP_W-1:0] OP_ADDI  = 4'b0011;
  localparam logic [OP_W-1:0] OP_LW    = 4'b0100;
  localparam logic [OP_W-1:0] OP_SW    = 4'b0101;
  localparam logic [OP_W-1:0] OP_BEQ   = 4'b0110;
  localparam logic [OP_W-1:0] OP_BNE   = 4'b0111;
  localparam logic [OP_W-1:0] OP_FOR   = 4'b1000;

  localparam logic [FUNC_W-1:0] FN_JMP  = 3'b000;
  localparam logic [FUNC_W-1:0] FN_CALL = 3'b001;
  localparam logic [FUNC_W-1:0] FN_RET  = 3'b010;
  localparam logic [FUNC_W-1:0] FN_SRL  = 3'b100;

  localparam logic [ALU_W-1:0] ALU_AND = 3'b000;
  localparam logic [ALU_W-1:0] ALU_ADD = 3'b001;
  localparam logic [ALU_W-1:0] ALU_SUB = 3'b010;

  localparam logic [PC_W-1:0] PC_NEXT   = 2'b00;
  localparam logic [PC_W-1:0] PC_JUMP   = 2'b01;
  localparam logic [PC_W-1:0] PC_BRANCH = 2'b10;
  localparam logic [PC_W-1:0] PC_RET    = 2'b11;

  logic [ALU_W-1:0] dec_alu_op;
  logic             dec_alu_src;
  logic             dec_reg_wr;
  logic             dec_mem_rd;
  logic             dec_mem_wr;
  logic [PC_W-1:0]  dec_pc_src;
  logic             dec_noop;
  logic             dec_alu_inst;
  logic             dec_branch;

  // Instruction decode: register selects, flags and raw EX-stage control
  always_comb begin
    RegSrc1         = 1'b0;
    RegSrc2         = 2'b00;
    RegDest         = 1'b0;
    sign_extend_imm = 1'b0;
    PCsrcJType      = 1'b0;
    RRSrc           = 1'b0;
    dec_alu_op      = ALU_AND;
    dec_alu_src     = 1'b0;
    dec_reg_wr      = 1'b0;
    dec_mem_rd      = 1'b0;
    dec_mem_wr      = 1'b0;
    dec_pc_src      = PC_NEXT;
    dec_noop        = 1'b0;
    dec_alu_inst    = 1'b0;
    dec_branch      = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        if (functionCode <= FN_SRL) begin
          dec_alu_op   = ALU_W'(functionCode);
          dec_reg_wr   = 1'b1;
          dec_alu_inst = 1'b1;
        end else begin
          dec_noop = 1'b1;
        end
      end
      OP_JTYPE: begin
        PCsrcJType = 1'b1;
        case (functionCode)
          FN_JMP:  dec_pc_src = PC_JUMP;
          FN_CALL: begin
            dec_pc_src = PC_JUMP;
            RRSrc      = 1'b1;
            RegDest    = 1'b1;
            dec_reg_wr = 1'b1;
          end
          FN_RET: begin
            dec_pc_src = PC_RET;
            RegSrc1    = 1'b1;
          end
          default: dec_noop = 1'b1;
        endcase
      end
      OP_ANDI: begin
        dec_alu_op   = ALU_AND;
        dec_alu_src  = 1'b1;
        dec_reg_wr   = 1'b1;
        dec_alu_inst = 1'b1;
      end
      OP_ADDI: begin
        dec_alu_op      = ALU_ADD;
        dec_alu_src     = 1'b1;
        dec_reg_wr      = 1'b1;
        dec_alu_inst    = 1'b1;
        sign_extend_imm = 1'b1;
      end
      OP_LW: begin
        dec_alu_op      = ALU_ADD;
        dec_alu_src     = 1'b1;
        dec_reg_wr      = 1'b1;
        dec_mem_rd      = 1'b1;
        sign_extend_imm = 1'b1;
      end
      OP_SW: begin
        dec_alu_op      = ALU_ADD;
        dec_alu_src     = 1'b1;
        dec_mem_wr      = 1'b1;
        sign_extend_imm = 1'b1;
        RegSrc2         = 2'b01;
      end
      OP_BEQ, OP_BNE, OP_FOR: begin
        dec_alu_op      = ALU_SUB;
        dec_branch      = 1'b1;
        sign_extend_imm = 1'b1;
        RegSrc2         = 2'b01;
        dec_reg_wr      = (opcode == OP_FOR);
        // BEQ takes on equal operands; BNE and FOR take on unequal ones
        if ((opcode == OP_BEQ) ? Z : !Z) dec_pc_src = PC_BRANCH;
      end
      default: dec_noop = 1'b1;
    endcase
  end

  // Stall suppresses redirection and per-instruction ID flags
  assign NOOP          = dec_noop;
  assign PCSrc         = stall ? PC_NEXT : dec_pc_src;
  assign killF         = (PCSrc != PC_NEXT);
  assign CntInst       = !stall && !dec_noop;
  assign ALUInst       = !stall && dec_alu_inst;
  assign BRANCH_OR_FOR = !stall && dec_branch;
  assign DMemWr        = !stall && dec_mem_wr;

  // ID/EX register; a stall loads a bubble
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      EXALUOp     <= '0;
      EXALUSrc    <= 1'b0;
      EXMemDataIn <= 1'b0;
      EXRegWr     <= 1'b0;
      EXMemRd     <= 1'b0;
      EXMemWr     <= 1'b0;
    end else if (stall) begin
      EXALUOp     <= '0;
      EXALUSrc    <= 1'b0;
      EXMemDataIn <= 1'b0;
      EXRegWr     <= 1'b0;
      EXMemRd     <= 1'b0;
      EXMemWr     <= 1'b0;
    end else begin
      EXALUOp     <= dec_alu_op;
      EXALUSrc    <= dec_alu_src;
      EXMemDataIn <= dec_mem_wr;
      EXRegWr     <= dec_reg_wr;
      EXMemRd     <= dec_mem_rd;
      EXMemWr     <= dec_mem_wr;
    end
  end

  // EX/MEM register; only loads select memory data for write-back
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      MEMMemRd  <= 1'b0;
      MEMMemWr  <= 1'b0;
      MEMRegWr  <= 1'b0;
      MEMWBdata <= 1'b0;
    end else begin
      MEMMemRd  <= EXMemRd;
      MEMMemWr  <= EXMemWr;
      MEMRegWr  <= EXRegWr;
      MEMWBdata <= EXMemRd;
    end
  end

  // MEM/WB register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) WBRegWr <= 1'b0;
    else        WBRegWr <= MEMRegWr;
  end

endmodule

// File: tb/tb_controller.sv
// tb_controller: directed self-checking bench for the pipeline controller.
module tb_controller;

  logic       clk;
  logic       reset;
  logic [3:0] opcode;
  logic [2:0] functionCode;
  logic       Z;
  logic       stall;
  logic       RegSrc1;
  logic [1:0] RegSrc2;
  logic       RegDest;
  logic       sign_extend_imm;
  logic [1:0] PCSrc;
  logic       killF;
  logic       PCsrcJType;
  logic       RRSrc;
  logic       NOOP;
  logic       CntInst;
  logic       ALUInst;
  logic       BRANCH_OR_FOR;
  logic       DMemWr;
  logic [2:0] EXALUOp;
  logic       EXALUSrc;
  logic       EXMemDataIn;
  logic       EXRegWr;
  logic       EXMemRd;
  logic       EXMemWr;
  logic       MEMMemRd;
  logic       MEMMemWr;
  logic       MEMRegWr;
  logic       MEMWBdata;
  logic       WBRegWr;

  int n_checks = 0;
  int n_fail   = 0;

  controller dut (
    .clk(clk), .reset(reset), .opcode(opcode), .functionCode(functionCode),
    .Z(Z), .stall(stall), .RegSrc1(RegSrc1), .RegSrc2(RegSrc2), .RegDest(RegDest),
    .sign_extend_imm(sign_extend_imm), .PCSrc(PCSrc), .killF(killF),
    .PCsrcJType(PCsrcJType), .RRSrc(RRSrc), .NOOP(NOOP), .CntInst(CntInst),
    .ALUInst(ALUInst), .BRANCH_OR_FOR(BRANCH_OR_FOR), .DMemWr(DMemWr),
    .EXALUOp(EXALUOp), .EXALUSrc(EXALUSrc), .EXMemDataIn(EXMemDataIn),
    .EXRegWr(EXRegWr), .EXMemRd(EXMemRd), .EXMemWr(EXMemWr),
    .MEMMemRd(MEMMemRd), .MEMMemWr(MEMMemWr), .MEMRegWr(MEMRegWr),
    .MEMWBdata(MEMWBdata), .WBRegWr(WBRegWr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // All registered outputs packed for one-shot comparison
  logic [12:0] regs;
  assign regs = {EXALUOp, EXALUSrc, EXMemDataIn, EXRegWr, EXMemRd, EXMemWr,
                 MEMMemRd, MEMMemWr, MEMRegWr, MEMWBdata, WBRegWr};

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic instr(input logic [3:0] op, input logic [2:0] fn, input logic z, input logic st);
    opcode = op; functionCode = fn; Z = z; stall = st;
    #1;
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    instr(4'b0000, 3'b001, 1'b0, 1'b0);
    // Clock edge while reset is held must not load anything
    edge1();
    chk("reset_regs", 16'(regs), 16'h0);
    chk("reset_comb_aluinst", 16'(ALUInst), 16'h1);
    reset = 1'b1;

    // ADD
    instr(4'b0000, 3'b001, 1'b0, 1'b0);
    chk("add_regsrc2", 16'(RegSrc2), 16'h0);
    chk("add_regdest", 16'(RegDest), 16'h0);
    chk("add_aluinst", 16'(ALUInst), 16'h1);
    chk("add_cntinst", 16'(CntInst), 16'h1);
    chk("add_pcsrc", 16'(PCSrc), 16'h0);
    chk("add_noop", 16'(NOOP), 16'h0);
    edge1();
    chk("add_ex_aluop", 16'(EXALUOp), 16'h1);
    chk("add_ex_alusrc", 16'(EXALUSrc), 16'h0);
    chk("add_ex_regwr", 16'(EXRegWr), 16'h1);
    instr(4'b1111, 3'b000, 1'b0, 1'b0);
    edge1();
    chk("add_mem_regwr", 16'(MEMRegWr), 16'h1);
    chk("noop_ex_regwr", 16'(EXRegWr), 16'h0);
    edge1();
    chk("add_wb_regwr", 16'(WBRegWr), 16'h1);

    // LW followed by SW
    instr(4'b0100, 3'b000, 1'b0, 1'b0);
    chk("lw_signext", 16'(sign_extend_imm), 16'h1);
    chk("lw_cnt_alu", 16'({CntInst, ALUInst}), 16'h2);
    edge1();
    chk("lw_ex", 16'({EXALUOp, EXALUSrc, EXMemRd, EXRegWr, EXMemWr}), 16'b001_1_1_1_0);
    instr(4'b0101, 3'b000, 1'b0, 1'b0);
    chk("sw_dmemwr", 16'(DMemWr), 16'h1);
    chk("sw_regsrc2", 16'(RegSrc2), 16'h1);
    chk("sw_signext", 16'(sign_extend_imm), 16'h1);
    edge1();
    chk("lw_mem", 16'({MEMMemRd, MEMWBdata, MEMRegWr}), 16'b111);
    chk("sw_ex", 16'({EXMemWr, EXMemDataIn, EXRegWr, EXALUSrc}), 16'b1101);
    instr(4'b1111, 3'b000, 1'b0, 1'b0);
    edge1();
    chk("sw_mem", 16'({MEMMemWr, MEMRegWr, MEMWBdata, MEMMemRd}), 16'b1000);
    chk("lw_wb", 16'(WBRegWr), 16'h1);
    edge1();
    chk("sw_wb", 16'(WBRegWr), 16'h0);

    // Branches
    instr(4'b0110, 3'b000, 1'b1, 1'b0);
    chk("beq_z1", 16'({PCSrc, killF, BRANCH_OR_FOR, RegSrc2}), 16'b10_1_1_01);
    instr(4'b0110, 3'b000, 1'b0, 1'b0);
    chk("beq_z0", 16'({PCSrc, killF, BRANCH_OR_FOR}), 16'b00_0_1);
    instr(4'b0111, 3'b000, 1'b0, 1'b0);
    chk("bne_z0", 16'({PCSrc, killF}), 16'b10_1);
    instr(4'b0111, 3'b000, 1'b1, 1'b0);
    chk("bne_z1", 16'({PCSrc, killF}), 16'b00_0);
    instr(4'b1000, 3'b000, 1'b0, 1'b0);
    chk("for_z0", 16'(PCSrc), 16'h2);
    instr(4'b1000, 3'b000, 1'b1, 1'b0);
    chk("for_z1", 16'({PCSrc, BRANCH_OR_FOR, sign_extend_imm}), 16'b00_1_1);
    edge1();
    chk("for_ex", 16'({EXRegWr, EXALUOp, EXALUSrc}), 16'b1_010_0);

    // J-type
    instr(4'b0001, 3'b000, 1'b0, 1'b0);
    chk("jmp", 16'({PCSrc, PCsrcJType, killF, CntInst, RRSrc}), 16'b01_1_1_1_0);
    instr(4'b0001, 3'b001, 1'b0, 1'b0);
    chk("call", 16'({PCSrc, RRSrc, RegDest, RegSrc1}), 16'b01_1_1_0);
    edge1();
    chk("call_ex_regwr", 16'(EXRegWr), 16'h1);
    instr(4'b0001, 3'b010, 1'b0, 1'b0);
    chk("ret", 16'({PCSrc, RegSrc1, killF, RegDest}), 16'b11_1_1_0);
    edge1();
    chk("ret_ex", 16'({EXRegWr, EXALUOp}), 16'h0);
    instr(4'b0001, 3'b011, 1'b0, 1'b0);
    chk("jtype_bad_func", 16'({NOOP, CntInst, PCSrc}), 16'b1_0_00);

    // ANDI and other R-type functions
    instr(4'b0010, 3'b000, 1'b0, 1'b0);
    chk("andi", 16'({sign_extend_imm, ALUInst}), 16'b01);
    edge1();
    chk("andi_ex", 16'({EXALUOp, EXALUSrc, EXRegWr}), 16'b000_1_1);
    instr(4'b0000, 3'b100, 1'b0, 1'b0);
    edge1();
    chk("srl_ex_aluop", 16'(EXALUOp), 16'h4);
    instr(4'b0000, 3'b101, 1'b0, 1'b0);
    chk("rtype_bad_func", 16'({NOOP, CntInst, ALUInst}), 16'b100);

    // NOOP encodings drain to all-zero pipeline
    instr(4'b1010, 3'b000, 1'b0, 1'b0);
    chk("op1010", 16'({NOOP, CntInst}), 16'b10);
    instr(4'b1111, 3'b000, 1'b0, 1'b0);
    chk("op1111", 16'({NOOP, CntInst}), 16'b10);
    edge1(); edge1(); edge1();
    chk("noop_drained", 16'(regs), 16'h0);

    // Stall: bubble into EX while older LW advances to MEM
    instr(4'b0100, 3'b000, 1'b0, 1'b0);
    edge1();
    instr(4'b0000, 3'b001, 1'b0, 1'b1);
    chk("stall_id", 16'({ALUInst, CntInst, PCSrc, killF}), 16'h0);
    edge1();
    chk("stall_ex", 16'({EXALUOp, EXALUSrc, EXMemDataIn, EXRegWr, EXMemRd, EXMemWr}), 16'h0);
    chk("stall_mem_adv", 16'({MEMMemRd, MEMWBdata, MEMRegWr}), 16'b111);
    instr(4'b0110, 3'b000, 1'b1, 1'b1);
    chk("stall_beq", 16'({PCSrc, killF, BRANCH_OR_FOR}), 16'h0);
    instr(4'b0101, 3'b000, 1'b0, 1'b1);
    chk("stall_sw", 16'(DMemWr), 16'h0);

    // Asynchronous reset mid-pipeline
    instr(4'b0100, 3'b000, 1'b0, 1'b0);
    edge1();
    instr(4'b0000, 3'b001, 1'b0, 1'b0);
    edge1();
    chk("pre_reset_busy", 16'({EXRegWr, MEMMemRd}), 16'b11);
    #2;
    reset = 1'b0;
    #1;
    chk("async_reset", 16'(regs), 16'h0);
    edge1();
    chk("reset_held", 16'(regs), 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
